sub_16bit_serial: RTL
=====================

# sub_16bit_serial

Multi-cycle 16-bit subtractor computing Diff = A − B one 4-bit nibble per cycle, least-significant nibble first, carrying the borrow between cycles. Serves as the subtract/compare path beside the ripple adders in the ALU, trading three extra cycles for a single 4-bit subtract slice. Produces borrow, signed-overflow, negative and zero flags for the flag register. Uses a start/busy/done handshake.

## Interface
Parameters:
- none; width fixed at 16 bits, processed as 4 nibbles

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- A  input  16  minuend; sampled on the accepting edge
- B  input  16  subtrahend; sampled on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result is valid
- Diff  output  16  result; held until the next accepted start
- B_out  output  1  borrow out; 1 iff A < B unsigned
- Ovfl  output  1  signed overflow of A − B
- Neg  output  1  Diff[15] of the final (post-saturation) result
- Zero  output  1  final Diff == 16'h0000

## Operation
- States:
  - IDLE, RUN, DONE.
  - IDLE/DONE + start → RUN: latch A and B, clear nibble counter, borrow-in = 0 (carry-in = 1).
  - RUN → RUN while counter < 3.
  - RUN → DONE after nibble 3.
  - DONE → IDLE without start.
  - DONE → RUN on start (back-to-back).
- Arithmetic:
  - Per RUN cycle, nibble i: A[i] + ~B[i] + carry.
  - Write the 4-bit sum into Diff[4i+3:4i]; the carry-out feeds the next nibble.
  - B_out = ~carry-out of nibble 3.
  - Ovfl = (A[15] != B[15]) && (raw[15] != A[15]), using the latched operands.
- start in RUN is ignored; A and B are don't-care outside the accepting edge.
- Diff and the flags update only on the final RUN edge.
  - Intermediate nibbles go to an internal raw register.
  - Visible Diff and flags keep the previous result until done.
- Reset, at any time including mid-RUN:
  - State goes to IDLE, the counter clears and the partial result is discarded.
  - Diff = 16'h0000, B_out/Ovfl/Neg = 0, Zero = 1, busy = 0, done = 0.

## Timing
- start sampled high at edge k (IDLE/DONE) → busy high from k through k+4; nibbles 0..3 computed on edges k+1..k+4.
- done high for exactly the one cycle after edge k+4; Diff and flags valid from that same cycle.
- Latency: 4 cycles from the accepting edge to done.
- Throughput: one operation per 5 cycles; start held high continuously yields back-to-back operations with done every 5th cycle.
- busy and done are never high together; all outputs are registered.

## Configuration
- SUB_SAT_EN defined: when Ovfl = 1, Diff saturates.
  - A[15] = 0 gives 16'h7FFF; A[15] = 1 gives 16'h8000.
  - Neg and Zero derive from the saturated value; Ovfl still reports 1.
- SUB_SAT_EN undefined: Diff is the wrapped two's-complement result, and no saturation logic is present.

## Structure
- Shared package holds:
  - state encoding IDLE/RUN/DONE
  - NIBBLES = 4
  - SAT_POS = 16'h7FFF, SAT_NEG = 16'h8000
- One sub-module, sub_slice_4bit: combinational A + ~B + C_in over 4 bits, built from full_adder_1bit, with outputs sum and C_out.
  - Instantiated once and muxed by the nibble counter.
- Top level holds the FSM, counter, operand/raw registers, flag logic and the optional saturation stage.

## Test plan
- A = 16'h1234, B = 16'h0234, start pulse → done 4 cycles later.
  - Diff = 16'h1000, B_out = 0, Ovfl = 0, Neg = 0, Zero = 0.
  - busy high for exactly 4 cycles.
- A = 16'h0000, B = 16'h0001 → Diff = 16'hFFFF, B_out = 1, Neg = 1, Ovfl = 0.
- A = 16'h8000, B = 16'h0001 → Ovfl = 1.
  - Without macro: Diff = 16'h7FFF, Neg = 0.
  - With SUB_SAT_EN: Diff = 16'h8000, Neg = 1.
- A = 16'h7FFF, B = 16'hFFFF → Ovfl = 1, B_out = 1.
  - Without macro: Diff = 16'h8000.
  - With SUB_SAT_EN: Diff = 16'h7FFF.
- A = B = 16'hBEEF → Diff = 0, Zero = 1, B_out = 0; then a second start pulse in RUN with A = 1, B = 0 → ignored, result stays 0.
- Reset asserted during the 2nd RUN cycle → immediately busy = 0, Diff = 0, Zero = 1, no done pulse.
  - A new start after reset release completes normally.

Source files
------------

// File: rtl/sub_16bit_serial_pkg.sv
// Shared definitions for the nibble-serial 16-bit subtractor.
// Optional saturation is enabled by defining SUB_SAT_EN.
package sub_16bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLES = 4;
    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/sub_16bit_serial_slice.sv
// 4-bit subtract slice: sum = A + ~B + C_in, built from 1-bit full adders.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    always_comb begin
        sum   = a ^ b ^ c_in;
        c_out = (a & b) | (c_in & (a ^ b));
    end
endmodule

module sub_slice_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_in,
    output logic [3:0] sum,
    output logic       C_out
);
    logic [4:0] c;

    assign c[0]  = C_in;
    assign C_out = c[4];

    for (genvar i = 0; i < 4; i++) begin : g_bit
        full_adder_1bit u_fa (
            .a     (A[i]),
            .b     (~B[i]),
            .c_in  (c[i]),
            .sum   (sum[i]),
            .c_out (c[i+1])
        );
    end
endmodule

// File: rtl/sub_16bit_serial.sv
// Multi-cycle 16-bit subtractor, one nibble per cycle, LSB nibble first.
// Define SUB_SAT_EN to saturate Diff on signed overflow.
module sub_16bit_serial
    import sub_16bit_serial_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] Diff,
    output logic        B_out,
    output logic        Ovfl,
    output logic        Neg,
    output logic        Zero
);
    state_t      state, state_nx;
    logic [1:0]  cnt;
    logic [15:0] a_q, b_q;
    logic [11:0] raw;
    logic        carry;
    logic [3:0]  a_nib, b_nib, nib_sum;
    logic        nib_cout;
    logic        accept, last;
    logic [15:0] raw_full, diff_fin;
    logic        ovfl_fin;

    sub_slice_4bit u_slice (
        .A     (a_nib),
        .B     (b_nib),
        .C_in  (carry),
        .sum   (nib_sum),
        .C_out (nib_cout)
    );

    always_comb begin
        case (cnt)
            2'd0:    begin a_nib = a_q[3:0];   b_nib = b_q[3:0];   end
            2'd1:    begin a_nib = a_q[7:4];   b_nib = b_q[7:4];   end
            2'd2:    begin a_nib = a_q[11:8];  b_nib = b_q[11:8];  end
            default: begin a_nib = a_q[15:12]; b_nib = b_q[15:12]; end
        endcase
    end

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (cnt == 2'(NIBBLES - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Final nibble is combined with the stored lower 12 bits in the same cycle.
    always_comb begin
        raw_full = {nib_sum, raw};
        ovfl_fin = (a_q[15] != b_q[15]) && (nib_sum[3] != a_q[15]);
`ifdef SUB_SAT_EN
        diff_fin = ovfl_fin ? (a_q[15] ? SAT_NEG : SAT_POS) : raw_full;
`else
        diff_fin = raw_full;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            raw   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Diff  <= '0;
            B_out <= 1'b0;
            Ovfl  <= 1'b0;
            Neg   <= 1'b0;
            Zero  <= 1'b1;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == RUN);
            done  <= (state_nx == DONE);
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                cnt   <= '0;
                carry <= 1'b1;
            end else if (state == RUN) begin
                carry <= nib_cout;
                cnt   <= cnt + 2'd1;
                case (cnt)
                    2'd0:    raw[3:0]  <= nib_sum;
                    2'd1:    raw[7:4]  <= nib_sum;
                    2'd2:    raw[11:8] <= nib_sum;
                    default: ;
                endcase
                if (last) begin
                    Diff  <= diff_fin;
                    B_out <= ~nib_cout;
                    Ovfl  <= ovfl_fin;
                    Neg   <= diff_fin[15];
                    Zero  <= (diff_fin == '0);
                end
            end
        end
    end

endmodule
